// File: rtl/cand_pkg.sv
// Shared types and defaults for the minimum-cost candidate selector.
package cand_pkg;

    localparam int DEF_COST_W = 16;
    localparam int DEF_IDX_W  = 8;

    typedef logic [DEF_COST_W-1:0] cost_t;
    typedef logic [DEF_IDX_W-1:0]  idx_t;
    typedef logic [DEF_IDX_W:0]    cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/cand_cmp.sv
// Unsigned magnitude compare of a against b; exactly one of lt/eq/gt is high.
module cand_cmp #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt,
    output logic         eq,
    output logic         gt
);

    assign lt = (a < b);
    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/cand_best_select.sv
// Streaming first-minimum selector over a candidate cost group.
// Optional tie counter (out_ties) enabled by defining CAND_TIE_CNT_EN.
module cand_best_select
    import cand_pkg::*;
#(
    parameter int COST_W = DEF_COST_W,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COST_W-1:0] in_cost,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COST_W-1:0] out_cost,
    output logic [IDX_W-1:0]  out_idx,
    output logic [IDX_W:0]    out_count,
    output logic              out_ovf
`ifdef CAND_TIE_CNT_EN
    ,
    output logic [IDX_W:0]    out_ties
`endif
);

    localparam logic [IDX_W:0]   CNT_MAX = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0]   CNT_ONE = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

    function automatic logic [IDX_W:0] sat_inc(input logic [IDX_W:0] c);
        if (c == CNT_MAX) begin
            return c;
        end else begin
            return c + CNT_ONE;
        end
    endfunction

    state_t              state_q, state_d;
    logic [COST_W-1:0]   best_q, best_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W:0]      cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic                xfer_s, cnt_full_s;
    logic                lt_s, eq_s, gt_s;

    cand_cmp #(.W(COST_W)) u_cmp (
        .a  (in_cost),
        .b  (best_q),
        .lt (lt_s),
        .eq (eq_s),
        .gt (gt_s)
    );

    assign xfer_s     = in_valid & ready_q;
    assign cnt_full_s = (cnt_q == CNT_MAX);

`ifdef CAND_TIE_CNT_EN
    logic [IDX_W:0] ties_q, ties_d;
    logic           unused_cmp_s;
    assign unused_cmp_s = gt_s;
    assign out_ties     = ties_q;
`else
    logic           unused_cmp_s;
    assign unused_cmp_s = ^{eq_s, gt_s};
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (xfer_s) begin
                    state_d = in_last ? HOLD : ACCUM;
                end else begin
                    state_d = state_q;
                end
            end
            HOLD: begin
                if (valid_q && out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and handshake next values; a group's first beat always seeds the registers
    always_comb begin
        best_d  = best_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
`ifdef CAND_TIE_CNT_EN
        ties_d  = ties_q;
`endif
        valid_d = (state_d == HOLD);
        ready_d = (state_d != HOLD);
        case (state_q)
            IDLE: begin
                if (xfer_s) begin
                    best_d = in_cost;
                    idx_d  = {IDX_W{1'b0}};
                    cnt_d  = CNT_ONE;
                    ovf_d  = 1'b0;
`ifdef CAND_TIE_CNT_EN
                    ties_d = CNT_ONE;
`endif
                end else begin
                    best_d = best_q;
                end
            end
            ACCUM: begin
                if (xfer_s) begin
                    // Once saturated, count stays put and the overflow flag sticks
                    if (cnt_full_s) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (lt_s) begin
                        best_d = in_cost;
                        idx_d  = cnt_full_s ? IDX_MAX : cnt_q[IDX_W-1:0];
                    end else begin
                        idx_d  = idx_q;
                    end
`ifdef CAND_TIE_CNT_EN
                    if (lt_s) begin
                        ties_d = CNT_ONE;
                    end else if (eq_s) begin
                        ties_d = sat_inc(ties_q);
                    end else begin
                        ties_d = ties_q;
                    end
`endif
                end else begin
                    best_d = best_q;
                end
            end
            default: begin
                best_d = best_q;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q  <= {COST_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            cnt_q   <= {(IDX_W+1){1'b0}};
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
`ifdef CAND_TIE_CNT_EN
            ties_q  <= {(IDX_W+1){1'b0}};
`endif
        end else begin
            best_q  <= best_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
`ifdef CAND_TIE_CNT_EN
            ties_q  <= ties_d;
`endif
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_cost  = best_q;
    assign out_idx   = idx_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cand_best_select.sv
// Randomized self-checking bench for cand_best_select against a first-minimum group model.
module tb_cand_best_select;

    localparam int COST_W = 16;
    localparam int IDX_W  = 8;
    localparam int GMAX   = 1 << IDX_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [COST_W-1:0] in_cost;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [COST_W-1:0] out_cost;
    logic [IDX_W-1:0]  out_idx;
    logic [IDX_W:0]    out_count;
    logic              out_ovf;
`ifdef CAND_TIE_CNT_EN
    logic [IDX_W:0]    out_ties;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cand_best_select #(.COST_W(COST_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cost   (in_cost),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cost  (out_cost),
        .out_idx   (out_idx),
        .out_count (out_count),
        .out_ovf   (out_ovf)
`ifdef CAND_TIE_CNT_EN
        ,
        .out_ties  (out_ties)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one group beat by beat with random gaps; with_last=0 leaves the group open.
    task automatic send_group(input int costs[$], input int gap_pct, input bit with_last);
        for (int i = 0; i < costs.size(); i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_cost  = costs[i][COST_W-1:0];
            in_last  = with_last && (i == costs.size() - 1);
            for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
            if (!in_ready) begin
                check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Model the group result from the costs alone and check the held result, then release it.
    task automatic get_result(input int costs[$], input int hold, input string tag);
        int minv, first, n, ties, e_idx, e_cnt, e_ovf;
        n = costs.size();
        minv = costs[0];
        first = 0;
        foreach (costs[i]) if (costs[i] < minv) begin minv = costs[i]; first = i; end
        ties = 0;
        foreach (costs[i]) if (costs[i] == minv) ties++;
        if (ties > GMAX) ties = GMAX;
        e_idx = (first > GMAX - 1) ? GMAX - 1 : first;
        e_cnt = (n > GMAX) ? GMAX : n;
        e_ovf = (n > GMAX) ? 1 : 0;

        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        for (int h = 0; h <= hold; h++) begin
            check({tag, ".cost"},  {16'd0, out_cost}, minv);
            check({tag, ".idx"},   {24'd0, out_idx}, e_idx);
            check({tag, ".count"}, {23'd0, out_count}, e_cnt);
            check({tag, ".ovf"},   {31'd0, out_ovf}, e_ovf);
`ifdef CAND_TIE_CNT_EN
            check({tag, ".ties"},  {23'd0, out_ties}, ties);
`endif
            check({tag, ".rdy_hold"}, {31'd0, in_ready}, 32'd0);
            if (h < hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".drop"},  {31'd0, out_valid}, 32'd0);
        check({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int q[$];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_cost   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.ready", {31'd0, in_ready}, 32'd0);
        check("rst.cost",  {16'd0, out_cost}, 32'd0);
        check("rst.count", {23'd0, out_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: mixed group with a tied minimum
        q = '{40, 12, 25, 12};
        send_group(q, 0, 1'b1);
        check("t1.idx_const", {24'd0, out_idx}, 32'd1);
        get_result(q, 0, "t1");

        // Directed: single max-cost beat, result visible right after its transfer edge
        q = '{16'hFFFF};
        send_group(q, 0, 1'b1);
        get_result(q, 0, "t2");

        // Directed: long hold under backpressure
        q = '{5, 9, 2};
        send_group(q, 0, 1'b1);
        get_result(q, 5, "t3");

        // Directed: overflowing group, minimum on the 257th beat
        q = {};
        for (int i = 0; i < GMAX; i++) q.push_back(1000);
        q.push_back(5);
        send_group(q, 0, 1'b1);
        check("t4.ovf_const", {31'd0, out_ovf}, 32'd1);
        check("t4.idx_const", {24'd0, out_idx}, 32'd255);
        get_result(q, 0, "t4");

        // Directed: reset in the middle of a group discards it
        q = '{100, 50, 75};
        send_group(q, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5.valid", {31'd0, out_valid}, 32'd0);
        check("t5.ready", {31'd0, in_ready}, 32'd0);
        check("t5.cost",  {16'd0, out_cost}, 32'd0);
        check("t5.count", {23'd0, out_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5.post_valid", {31'd0, out_valid}, 32'd0);
        q = '{7, 3};
        send_group(q, 0, 1'b1);
        get_result(q, 0, "t5b");

        // Random groups with gaps, ties, extremes and backpressure
        for (int g = 0; g < 2000; g++) begin
            int n;
            n = $urandom_range(1, 8);
            q = {};
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       q.push_back($urandom_range(0, 7));
                    1:       q.push_back(($urandom_range(0, 1) == 1) ? 16'hFFFF : 0);
                    default: q.push_back($urandom & 16'hFFFF);
                endcase
            end
            send_group(q, 20, 1'b1);
            get_result(q, $urandom_range(0, 2), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
